// File: rtl/uart_rx_if.sv
// CPU-side register interface of the UART receiver.
// The rx_parity_err flag exists only when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       rx_overrun;
  logic       rx_frame_err;
  logic       rx_busy;
`ifdef UART_RX_PARITY_EN
  logic       rx_parity_err;
`endif

  modport master (
    output rx_data, rx_valid, rx_overrun, rx_frame_err, rx_busy,
`ifdef UART_RX_PARITY_EN
    output rx_parity_err,
`endif
    input  rx_ack
  );

  modport slave (
    input  rx_data, rx_valid, rx_overrun, rx_frame_err, rx_busy,
`ifdef UART_RX_PARITY_EN
    input  rx_parity_err,
`endif
    output rx_ack
  );
endinterface

// File: rtl/uart_rx.sv
// 16x oversampled 8N1 UART receiver with a one-byte holding register and sticky error flags.
// Defining UART_RX_PARITY_EN adds an even-parity bit (8E1) and the rx_parity_err flag.
`timescale 1ns/1ps
module uart_rx #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      rxd,
  uart_rx_if.master bus
);
  localparam int DIV   = (CLK_FREQ + BAUD * 8) / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

`ifdef UART_RX_PARITY_EN
  function automatic logic parity_ok(input logic [7:0] d, input logic p);
    return ~(^{d, p});
  endfunction
`endif

  state_t           state_r;
  logic             rxd_meta_r;
  logic             rxd_s;
  logic             rxd_prev_r;
  logic [DIV_W-1:0] div_cnt_r;
  logic [3:0]       samp_cnt_r;
  logic [2:0]       bit_idx_r;
  logic [7:0]       shift_r;
  logic             smp7_r;
  logic             smp8_r;
  logic             done_r;
  logic             ferr_r;
  logic             busy_r;
  logic [7:0]       rx_data_r;
  logic             rx_valid_r;
  logic             rx_overrun_r;
  logic             rx_frame_err_r;
`ifdef UART_RX_PARITY_EN
  logic             par_bit_r;
  logic             perr_r;
  logic             rx_parity_err_r;
`endif

  logic tick_s;
  logic start_s;
  logic decide_s;
  logic bit_end_s;
  logic bit_val_s;

  assign tick_s    = (div_cnt_r == DIV_W'(DIV - 1));
  assign start_s   = (state_r == ST_IDLE) && rxd_prev_r && !rxd_s;
  assign decide_s  = tick_s && (samp_cnt_r == 4'd9);
  assign bit_end_s = tick_s && (samp_cnt_r == 4'd15);
  assign bit_val_s = maj3(smp7_r, smp8_r, rxd_s);

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rxd_meta_r <= 1'b1;
      rxd_s      <= 1'b1;
      rxd_prev_r <= 1'b1;
    end else begin
      rxd_meta_r <= rxd;
      rxd_s      <= rxd_meta_r;
      rxd_prev_r <= rxd_s;
    end
  end

  // Oversample tick divider, re-phased on every start edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt_r <= '0;
    end else if (start_s || tick_s) begin
      div_cnt_r <= '0;
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
    end
  end

  // Frame state machine: bit sampling, shifting and one-cycle completion/error pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      samp_cnt_r <= 4'd0;
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'h00;
      smp7_r     <= 1'b1;
      smp8_r     <= 1'b1;
      done_r     <= 1'b0;
      ferr_r     <= 1'b0;
      busy_r     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_r  <= 1'b0;
      perr_r     <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      ferr_r <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_r <= 1'b0;
`endif
      if (tick_s && (state_r != ST_IDLE) && (state_r != ST_BREAK)) begin
        samp_cnt_r <= samp_cnt_r + 4'd1;
        if (samp_cnt_r == 4'd7) smp7_r <= rxd_s;
        if (samp_cnt_r == 4'd8) smp8_r <= rxd_s;
      end
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            state_r    <= ST_START;
            samp_cnt_r <= 4'd0;
            busy_r     <= 1'b1;
          end
        end
        ST_START: begin
          if (decide_s && bit_val_s) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else if (bit_end_s) begin
            state_r   <= ST_DATA;
            bit_idx_r <= 3'd0;
          end
        end
        ST_DATA: begin
          if (decide_s) shift_r[bit_idx_r] <= bit_val_s;
          if (bit_end_s) begin
            if (bit_idx_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_r <= ST_PARITY;
`else
              state_r <= ST_STOP;
`endif
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (decide_s) par_bit_r <= bit_val_s;
          if (bit_end_s) state_r <= ST_STOP;
        end
`endif
        ST_STOP: begin
          if (decide_s) begin
            if (bit_val_s) begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
`ifdef UART_RX_PARITY_EN
              if (parity_ok(shift_r, par_bit_r)) done_r <= 1'b1;
              else perr_r <= 1'b1;
`else
              done_r  <= 1'b1;
`endif
            end else begin
              ferr_r  <= 1'b1;
              state_r <= ST_BREAK;
            end
          end
        end
        ST_BREAK: begin
          if (rxd_s) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Holding register and sticky flags; a same-cycle new event beats the ack clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_data_r       <= 8'h00;
      rx_valid_r      <= 1'b0;
      rx_overrun_r    <= 1'b0;
      rx_frame_err_r  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      rx_parity_err_r <= 1'b0;
`endif
    end else begin
      if (done_r && (!rx_valid_r || bus.rx_ack)) begin
        rx_data_r  <= shift_r;
        rx_valid_r <= 1'b1;
      end else if (bus.rx_ack) begin
        rx_valid_r <= 1'b0;
      end
      rx_overrun_r    <= (done_r && rx_valid_r && !bus.rx_ack) || (rx_overrun_r && !bus.rx_ack);
      rx_frame_err_r  <= ferr_r || (rx_frame_err_r && !bus.rx_ack);
`ifdef UART_RX_PARITY_EN
      rx_parity_err_r <= perr_r || (rx_parity_err_r && !bus.rx_ack);
`endif
    end
  end

  assign bus.rx_data      = rx_data_r;
  assign bus.rx_valid     = rx_valid_r;
  assign bus.rx_overrun   = rx_overrun_r;
  assign bus.rx_frame_err = rx_frame_err_r;
  assign bus.rx_busy      = busy_r;
`ifdef UART_RX_PARITY_EN
  assign bus.rx_parity_err = rx_parity_err_r;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: expected bytes are queued as frames are driven and popped on rx_valid.
// The line rate is raised (exact divider of 10) so the whole run stays short.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int      CLK_FREQ = 50000000;
  localparam int      BAUD     = 312500;
  localparam realtime BIT_NS   = 1.0e9 / BAUD;
  localparam int      TIMEOUT  = 4000;

  logic clk;
  logic reset;
  logic rxd;
  uart_rx_if bus();

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(16)) dut (
    .clk   (clk),
    .reset (reset),
    .rxd   (rxd),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int         checks;
  int         errors;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b, input int stop_len);
    rxd = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      #(BIT_NS);
    end
`ifdef UART_RX_PARITY_EN
    rxd = par_b;
    #(BIT_NS);
`endif
    rxd = stop_b;
    #(BIT_NS * stop_len);
    rxd = 1'b1;
  endtask

  task automatic expect_byte(input string tag, output realtime lat);
    realtime    t0;
    int         n;
    logic [7:0] e;
    t0 = $realtime;
    n  = 0;
    @(negedge clk);
    while (!bus.rx_valid && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    lat = $realtime - t0;
    if (!bus.rx_valid) chk({tag, "_timeout"}, 32'd0, 32'd1);
    else if (exp_q.size() == 0) chk({tag, "_unexpected"}, 32'd1, 32'd0);
    else begin
      e = exp_q.pop_front();
      chk(tag, bus.rx_data, e);
    end
  endtask

  task automatic do_ack();
    @(negedge clk) bus.rx_ack = 1'b1;
    @(negedge clk) bus.rx_ack = 1'b0;
  endtask

  task automatic send_and_expect(input logic [7:0] d, input string tag);
    realtime lat;
    exp_q.push_back(d);
    send_frame(d, 1'b1, ^d, 1);
    expect_byte(tag, lat);
  endtask

  initial begin
    realtime    lat;
    logic [7:0] d;
    checks     = 0;
    errors     = 0;
    rxd        = 1'b1;
    reset      = 1'b0;
    bus.rx_ack = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    chk("rst_valid", bus.rx_valid, 32'd0);
    chk("rst_data", bus.rx_data, 32'h00);
    chk("rst_ovr", bus.rx_overrun, 32'd0);
    chk("rst_ferr", bus.rx_frame_err, 32'd0);
    chk("rst_busy", bus.rx_busy, 32'd0);
    #(BIT_NS);

    // Single byte with latency measured from the start edge.
    d = 8'h01;
    exp_q.push_back(d);
    fork
      send_frame(d, 1'b1, ^d, 1);
      expect_byte("b01_data", lat);
    join
    chk("b01_lat", (lat > 9.3 * BIT_NS) && (lat < 9.9 * BIT_NS), 32'd1);
    chk("b01_ferr", bus.rx_frame_err, 32'd0);
    do_ack();
    chk("b01_ack_valid", bus.rx_valid, 32'd0);
    #(BIT_NS);

    // Back-to-back without ack: second byte is dropped.
    d = 8'hA5;
    exp_q.push_back(d);
    send_frame(d, 1'b1, ^d, 1);
    d = 8'h3C;
    send_frame(d, 1'b1, ^d, 1);
    expect_byte("b2b_data", lat);
    chk("b2b_ovr", bus.rx_overrun, 32'd1);
    chk("b2b_valid", bus.rx_valid, 32'd1);
    do_ack();
    chk("b2b_ack_valid", bus.rx_valid, 32'd0);
    chk("b2b_ack_ovr", bus.rx_overrun, 32'd0);
    chk("b2b_qempty", exp_q.size(), 32'd0);
    #(BIT_NS);

    // Framing error: stop bit held low for three bit times.
    d = 8'h55;
    send_frame(d, 1'b0, ^d, 3);
    repeat (6) @(negedge clk);
    chk("fe_ferr", bus.rx_frame_err, 32'd1);
    chk("fe_valid", bus.rx_valid, 32'd0);
    chk("fe_busy", bus.rx_busy, 32'd0);
    #(BIT_NS);
    do_ack();
    chk("fe_ack_ferr", bus.rx_frame_err, 32'd0);
    send_and_expect(8'h0F, "fe_next_data");
    chk("fe_next_ferr", bus.rx_frame_err, 32'd0);
    do_ack();
    #(BIT_NS);

    // Glitch far shorter than half a bit.
    @(negedge clk) rxd = 1'b0;
    #(BIT_NS * 0.1);
    rxd = 1'b1;
    repeat (4) @(negedge clk);
    chk("gl_busy_start", bus.rx_busy, 32'd1);
    #(BIT_NS);
    @(negedge clk);
    chk("gl_busy_end", bus.rx_busy, 32'd0);
    chk("gl_valid", bus.rx_valid, 32'd0);
    chk("gl_ferr", bus.rx_frame_err, 32'd0);
    chk("gl_ovr", bus.rx_overrun, 32'd0);

`ifdef UART_RX_PARITY_EN
    d = 8'h07;
    exp_q.push_back(d);
    send_frame(d, 1'b1, 1'b1, 1);
    expect_byte("par_ok_data", lat);
    chk("par_ok_perr", bus.rx_parity_err, 32'd0);
    do_ack();
    #(BIT_NS);
    send_frame(d, 1'b1, 1'b0, 1);
    repeat (6) @(negedge clk);
    chk("par_bad_perr", bus.rx_parity_err, 32'd1);
    chk("par_bad_valid", bus.rx_valid, 32'd0);
    do_ack();
    chk("par_ack_perr", bus.rx_parity_err, 32'd0);
    #(BIT_NS);
`endif

    // Reset during data bit 4; remaining bits are all 1 so no new start edge follows.
    d = 8'hF0;
    fork
      send_frame(d, 1'b1, ^d, 1);
      begin
        #(BIT_NS * 5.5);
        @(negedge clk);
        chk("mr_busy_before", bus.rx_busy, 32'd1);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        chk("mr_busy", bus.rx_busy, 32'd0);
        chk("mr_data", bus.rx_data, 32'h00);
      end
    join
    #(BIT_NS * 2);
    @(negedge clk);
    chk("mr_valid", bus.rx_valid, 32'd0);
    chk("mr_ferr", bus.rx_frame_err, 32'd0);
    chk("mr_qempty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver. Converts the asynchronous serial input pin `rxd` into bytes for the CPU's peripheral bus.
- Sits between the board pin and the CPU's UART data/status registers. The CPU polls `rx_valid` and pulses `rx_ack` after reading `rx_data`.
- Frame format: 8N1 (one start bit, 8 data bits LSB first, no parity, one stop bit) at a fixed baud rate, 16x oversampled.

Parameters:
- CLK_FREQ, 50000000: system clock frequency in Hz.
- BAUD, 9600: line rate in bit/s.
- OVERSAMPLE, 16: sample ticks per bit. Must be 16; the mid-bit sample indices below depend on it.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset.
- rxd  input  1  serial line, asynchronous, idles high.
- rx_data  output  8  last accepted byte.
- rx_valid  output  1  holding register contains an unread byte.
- rx_ack  input  1  one-cycle read strobe from the CPU.
- rx_overrun  output  1  sticky: a byte was dropped because the holding register was full.
- rx_frame_err  output  1  sticky: a stop bit was sampled low.
- rx_busy  output  1  a frame is in progress (state is not IDLE).

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE.
  - Synchronizer flops set to 1.
  - rx_data=8'h00; rx_valid, rx_overrun, rx_frame_err, rx_busy = 0.
  - Tick divider and all counters = 0.
  - Reset mid-frame aborts the frame; nothing is loaded.
- Input synchronizer: rxd passes through 2 flops to give rxd_s. All decisions use rxd_s.
- Tick generator:
  - DIV = (CLK_FREQ + BAUD*8) / (BAUD*16), integer division. Defaults give DIV = 326.
  - The counter counts 0..DIV-1 and emits a one-cycle tick on wrap.
  - The counter is cleared when a start edge is detected, so sampling is phase-aligned to the frame.
- Sample counter s (4 bits) counts ticks within a bit. Bit decision is the majority of rxd_s at s = 7, 8 and 9. The bit is committed at s = 9; the bit ends at s = 15 (wrap to 0).
- State machine:
  - IDLE:
    - A 1-to-0 transition on rxd_s moves to START; clear the divider and s.
    - rx_busy=0 only in this state.
  - START:
    - At s = 9: majority 0 → continue. Majority 1 → glitch, return to IDLE with no flags.
    - At the end of the bit (s = 15 wrap) → DATA, bit index n = 0.
  - DATA:
    - Each bit decision shifts into shift_reg[n].
    - After n = 7 completes → STOP.
  - STOP, at s = 9:
    - Majority 1 → byte complete → IDLE.
    - Majority 0 → set rx_frame_err and discard the byte → BREAK.
  - BREAK: stay until rxd_s == 1, then → IDLE.
- Byte hand-off:
  - On the clk after the STOP decision: if rx_valid == 0, rx_data <= shift_reg and rx_valid <= 1.
  - If rx_valid == 1 and no rx_ack that cycle: byte dropped, rx_overrun <= 1, rx_data unchanged.
  - rx_ack and byte completion in the same cycle: load the new byte, rx_valid stays 1, no overrun.
  - rx_ack with rx_valid == 0: no effect.
- Flag clearing: rx_ack clears rx_overrun and rx_frame_err on the same edge. A new error in that same cycle wins and the flag stays set.
- Latency: rx_valid rises 2 clk after the tick at s = 9 of the stop bit. That is about 9.5 bit times after the start-edge sample.
- Baud error: the defaults give a divider error below 0.2%, which is within the required ±2% tolerance.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - Even parity is checked: XOR of the 8 data bits and the parity bit must be 0.
  - A mismatch sets the sticky output rx_parity_err (extra 1-bit output port, cleared by rx_ack like the other flags) and discards the byte.
  - The frame is 11 bits long.
- Undefined:
  - No PARITY state and no rx_parity_err port.
  - Frame is 8N1, 10 bits.

Test Plan:
- Reset: hold reset=0 for 3 clk with rxd=1, release → all outputs 0, rx_busy=0, state IDLE.
- Single byte: send 8'h01 at 9600 baud (bit period 104166.667 ns, 20 ns clk) → rx_valid=1 about 989 µs after the start edge, rx_data=8'h01, rx_frame_err=0. Pulse rx_ack → rx_valid=0 next clk.
- Back-to-back without ack:
  - Send 8'hA5 then 8'h3C without rx_ack → rx_data stays 8'hA5, rx_overrun=1.
  - rx_ack → rx_valid=0, rx_overrun=0.
- Framing error: send 8'h55 with the stop bit held low, then rxd=1 after 3 bit times → rx_frame_err=1, rx_valid=0. The next frame 8'h0F is received correctly.
- Glitch rejection: drive rxd low for 2 µs in IDLE → no state advance past START, rx_valid=0, flags 0. Reset asserted mid-frame (during bit 4) → everything returns to reset values and the partial byte is never delivered.
- (UART_RX_PARITY_EN) Send 8'h07 with parity bit 1 → byte accepted. Same byte with parity bit 0 → rx_parity_err=1, rx_valid=0.
